// File: rtl/mcore_arb_pkg.sv
// Shared types and the round-robin helper for the mcore memory arbiter.
package mcore_arb_pkg;

  localparam int MAX_NUM_REQ = 8;

  // Sized for the largest supported requester count so one type serves every configuration.
  typedef logic [$clog2(MAX_NUM_REQ)-1:0] req_id_t;

  // First active request scanning upward from ptr+1; unused upper lanes are zero, so the
  // wrap through them is equivalent to a wrap modulo the real requester count.
  function automatic req_id_t rr_pick(input logic [MAX_NUM_REQ-1:0] req, input req_id_t ptr);
    req_id_t pick;
    req_id_t idx;
    logic    found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= MAX_NUM_REQ; k++) begin
      idx = ptr + req_id_t'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mcore_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered memory transactions.
module mcore_id_fifo
  import mcore_arb_pkg::*;
#(
  parameter int  DEPTH     = 4,
  localparam int PTR_WIDTH = $clog2(DEPTH),
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 push,
  input  req_id_t              push_id,
  input  logic                 pop,
  output req_id_t              head,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_WIDTH-1:0] count
);

  req_id_t              mem_r [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_r;
  logic [PTR_WIDTH-1:0] rd_ptr_r;
  logic [CNT_WIDTH-1:0] count_r;
  logic                 do_push_s;
  logic                 do_pop_s;

  assign full      = (count_r == CNT_WIDTH'(DEPTH));
  assign empty     = (count_r == {CNT_WIDTH{1'b0}});
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // ID storage and write pointer; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= req_id_t'(0);
      end
      wr_ptr_r <= {PTR_WIDTH{1'b0}};
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_id;
      wr_ptr_r        <= wr_ptr_r + {{(PTR_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Read pointer advance
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_ptr_r <= {PTR_WIDTH{1'b0}};
    end else if (do_pop_s) begin
      rd_ptr_r <= rd_ptr_r + {{(PTR_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_r <= rd_ptr_r;
    end
  end

  // Occupancy; a simultaneous push and pop leaves it unchanged
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mcore_mem_arbiter.sv
// Round-robin arbiter sharing the single PS memory port among mcore requesters;
// responses are steered back to their issuer through an in-order ID FIFO.
module mcore_mem_arbiter
  import mcore_arb_pkg::*;
#(
  parameter int  NUM_REQ    = 3,
  parameter int  ADDR_WIDTH = 32,
  parameter int  DATA_WIDTH = 32,
  parameter int  MAX_OUTST  = 4,
  localparam int BE_WIDTH   = DATA_WIDTH / 8,
  localparam int CNT_WIDTH  = $clog2(MAX_OUTST) + 1
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic [NUM_REQ-1:0]                  s_req,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  s_addr,
  input  logic [NUM_REQ-1:0]                  s_we,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  s_wdata,
  input  logic [NUM_REQ-1:0][BE_WIDTH-1:0]    s_be,
  output logic [NUM_REQ-1:0]                  s_gnt,
  output logic [NUM_REQ-1:0]                  s_rsp_valid,
  output logic [DATA_WIDTH-1:0]               s_rsp_rdata,
  output logic                                s_rsp_error,
  output logic                                m_req,
  output logic [ADDR_WIDTH-1:0]               m_addr,
  output logic                                m_we,
  output logic [DATA_WIDTH-1:0]               m_wdata,
  output logic [BE_WIDTH-1:0]                 m_be,
  input  logic                                m_gnt,
  input  logic                                m_rsp_valid,
  input  logic [DATA_WIDTH-1:0]               m_rsp_rdata,
  input  logic                                m_rsp_error,
  output logic                                busy,
  output logic                                orphan_err
);

  logic [MAX_NUM_REQ-1:0] req_pad_s;
  logic [NUM_REQ-1:0]     sel_oh_s;
  req_id_t                ptr_r;
  req_id_t                locked_sel_r;
  req_id_t                rr_sel_s;
  req_id_t                sel_s;
  req_id_t                head_s;
  logic                   lock_r;
  logic                   orphan_r;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic                   grant_s;
  logic                   pop_s;
  logic [CNT_WIDTH-1:0]   count_s;

  // Requester candidate: the held selection while a stalled request is pending, else round-robin
  always_comb begin
    req_pad_s              = {MAX_NUM_REQ{1'b0}};
    req_pad_s[NUM_REQ-1:0] = s_req;
    rr_sel_s               = rr_pick(req_pad_s, ptr_r);
    if (lock_r) begin
      sel_s = locked_sel_r;
    end else begin
      sel_s = rr_sel_s;
    end
  end

  // Full gating uses the registered count, so a same-cycle pop cannot admit a new request
  assign m_req       = (|s_req) && !fifo_full_s;
  assign grant_s     = m_req && m_gnt;
  assign pop_s       = m_rsp_valid && !fifo_empty_s;
  assign s_rsp_rdata = m_rsp_rdata;
  assign s_rsp_error = m_rsp_error;
  assign busy        = (count_s != {CNT_WIDTH{1'b0}}) || m_req;
  assign orphan_err  = orphan_r;

  // Downstream field mux and per-requester grant/response steering as AND-OR trees
  always_comb begin
    m_addr      = {ADDR_WIDTH{1'b0}};
    m_we        = 1'b0;
    m_wdata     = {DATA_WIDTH{1'b0}};
    m_be        = {BE_WIDTH{1'b0}};
    s_gnt       = {NUM_REQ{1'b0}};
    s_rsp_valid = {NUM_REQ{1'b0}};
    sel_oh_s    = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_oh_s[i]    = (sel_s == req_id_t'(i));
      m_addr         = m_addr  | (s_addr[i]  & {ADDR_WIDTH{sel_oh_s[i]}});
      m_wdata        = m_wdata | (s_wdata[i] & {DATA_WIDTH{sel_oh_s[i]}});
      m_be           = m_be    | (s_be[i]    & {BE_WIDTH{sel_oh_s[i]}});
      m_we           = m_we    | (s_we[i]    & sel_oh_s[i]);
      s_gnt[i]       = grant_s & sel_oh_s[i];
      s_rsp_valid[i] = pop_s & (head_s == req_id_t'(i));
    end
  end

  // Round-robin pointer and stall lock; both hold while the FIFO is full because m_req is low
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ptr_r        <= req_id_t'(0);
      lock_r       <= 1'b0;
      locked_sel_r <= req_id_t'(0);
    end else if (grant_s) begin
      ptr_r        <= sel_s;
      lock_r       <= 1'b0;
      locked_sel_r <= locked_sel_r;
    end else if (m_req && !m_gnt) begin
      ptr_r        <= ptr_r;
      lock_r       <= 1'b1;
      locked_sel_r <= sel_s;
    end else begin
      ptr_r        <= ptr_r;
      lock_r       <= lock_r;
      locked_sel_r <= locked_sel_r;
    end
  end

  // Sticky flag for responses that arrive with nothing outstanding
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      orphan_r <= 1'b0;
    end else if (m_rsp_valid && fifo_empty_s) begin
      orphan_r <= 1'b1;
    end else begin
      orphan_r <= orphan_r;
    end
  end

  mcore_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .aclk    (aclk),
    .areset  (areset),
    .push    (grant_s),
    .push_id (sel_s),
    .pop     (pop_s),
    .head    (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (count_s)
  );

endmodule

// File: tb/tb_mcore_mem_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_mcore_mem_arbiter;

  localparam int NUM_REQ   = 3;
  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int BEW       = DW / 8;
  localparam int MAX_OUTST = 4;

  logic                         aclk = 1'b0;
  logic                         areset;
  logic [NUM_REQ-1:0]           s_req;
  logic [NUM_REQ-1:0][AW-1:0]   s_addr;
  logic [NUM_REQ-1:0]           s_we;
  logic [NUM_REQ-1:0][DW-1:0]   s_wdata;
  logic [NUM_REQ-1:0][BEW-1:0]  s_be;
  logic [NUM_REQ-1:0]           s_gnt;
  logic [NUM_REQ-1:0]           s_rsp_valid;
  logic [DW-1:0]                s_rsp_rdata;
  logic                         s_rsp_error;
  logic                         m_req;
  logic [AW-1:0]                m_addr;
  logic                         m_we;
  logic [DW-1:0]                m_wdata;
  logic [BEW-1:0]               m_be;
  logic                         m_gnt;
  logic                         m_rsp_valid;
  logic [DW-1:0]                m_rsp_rdata;
  logic                         m_rsp_error;
  logic                         busy;
  logic                         orphan_err;

  mcore_mem_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_OUTST  (MAX_OUTST)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .s_req       (s_req),
    .s_addr      (s_addr),
    .s_we        (s_we),
    .s_wdata     (s_wdata),
    .s_be        (s_be),
    .s_gnt       (s_gnt),
    .s_rsp_valid (s_rsp_valid),
    .s_rsp_rdata (s_rsp_rdata),
    .s_rsp_error (s_rsp_error),
    .m_req       (m_req),
    .m_addr      (m_addr),
    .m_we        (m_we),
    .m_wdata     (m_wdata),
    .m_be        (m_be),
    .m_gnt       (m_gnt),
    .m_rsp_valid (m_rsp_valid),
    .m_rsp_rdata (m_rsp_rdata),
    .m_rsp_error (m_rsp_error),
    .busy        (busy),
    .orphan_err  (orphan_err)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // reference model: last winner, pending stalled winner, queue of outstanding (id, addr)
  int            last_win;
  bit            lock_v;
  int            lock_id;
  int            q_id[$];
  logic [AW-1:0] q_addr[$];
  bit            orphan_exp;
  bit            chk_data;

  // values seen in the most recent step
  logic [NUM_REQ-1:0] gnt_obs;
  logic [NUM_REQ-1:0] rsp_obs;
  logic               mreq_obs;
  logic               busy_obs;
  logic               orphan_obs;
  logic [AW-1:0]      maddr_obs;
  logic [DW-1:0]      rdata_obs;

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return a ^ 32'h5A3C_96E1;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // check one cycle at the falling edge, advance the model, then return just after the rising edge
  task automatic step();
    int                 win;
    bit                 mreq_e;
    bit                 gnt_e;
    bit                 rsp_e;
    logic [NUM_REQ-1:0] gnt_v;
    logic [NUM_REQ-1:0] rsp_v;
    @(negedge aclk);
    win = -1;
    if (lock_v) win = lock_id;
    else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (last_win + k) % NUM_REQ;
        if (win < 0 && s_req[c]) win = c;
      end
    end
    mreq_e = (|s_req) && (q_id.size() < MAX_OUTST);
    gnt_e  = mreq_e && m_gnt;
    gnt_v  = gnt_e ? NUM_REQ'(1 << win) : '0;
    rsp_e  = m_rsp_valid && (q_id.size() > 0);
    rsp_v  = rsp_e ? NUM_REQ'(1 << q_id[0]) : '0;
    check_val("m_req", m_req, mreq_e);
    check_val("s_gnt", s_gnt, gnt_v);
    check_val("s_rsp_valid", s_rsp_valid, rsp_v);
    check_val("busy", busy, (q_id.size() > 0) || mreq_e);
    check_val("orphan_err", orphan_err, orphan_exp);
    if (mreq_e) begin
      check_val("m_addr", m_addr, s_addr[win]);
      check_val("m_we", m_we, s_we[win]);
      check_val("m_wdata", m_wdata, s_wdata[win]);
      check_val("m_be", m_be, s_be[win]);
    end
    if (rsp_e && chk_data) begin
      check_val("rsp_rdata", s_rsp_rdata, mem_data(q_addr[0]));
      check_val("rsp_error", s_rsp_error, q_addr[0][0]);
    end
    gnt_obs = s_gnt; rsp_obs = s_rsp_valid; mreq_obs = m_req; busy_obs = busy;
    orphan_obs = orphan_err; maddr_obs = m_addr; rdata_obs = s_rsp_rdata;
    if (rsp_e) begin
      void'(q_id.pop_front());
      void'(q_addr.pop_front());
    end else if (m_rsp_valid) orphan_exp = 1'b1;
    if (gnt_e) begin
      q_id.push_back(win);
      q_addr.push_back(s_addr[win]);
      last_win = win;
      lock_v   = 1'b0;
    end else if (mreq_e && !m_gnt) begin
      lock_v  = 1'b1;
      lock_id = win;
    end
    @(posedge aclk);
    #1;
  endtask

  // memory side: answer the oldest outstanding transaction when enabled
  task automatic drive_mem(input bit en);
    m_rsp_valid = en && (q_id.size() > 0);
    if (q_id.size() > 0) begin
      m_rsp_rdata = mem_data(q_addr[0]);
      m_rsp_error = q_addr[0][0];
    end else begin
      m_rsp_rdata = $urandom;
      m_rsp_error = 1'b0;
    end
  endtask

  task automatic do_reset();
    areset = 1'b1;
    s_req = '0; s_addr = '0; s_we = '0; s_wdata = '0; s_be = '0;
    m_gnt = 1'b0; m_rsp_valid = 1'b0; m_rsp_rdata = '0; m_rsp_error = 1'b0;
    q_id.delete(); q_addr.delete();
    last_win = 0; lock_v = 1'b0; lock_id = 0; orphan_exp = 1'b0;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
  endtask

  task automatic drain();
    s_req = '0;
    for (int n = 0; n < 20 && q_id.size() > 0; n++) begin
      drive_mem(1'b1);
      step();
    end
    m_rsp_valid = 1'b0;
    step();
    check_val("drain_busy", busy_obs, 1'b0);
  endtask

  initial begin
    int grants;
    int order_exp[6];
    order_exp = '{1, 2, 0, 1, 2, 0};

    // reset state
    areset = 1'b1;
    s_req = '0; s_addr = '0; s_we = '0; s_wdata = '0; s_be = '0;
    m_gnt = 1'b0; m_rsp_valid = 1'b0; m_rsp_rdata = '0; m_rsp_error = 1'b0;
    @(negedge aclk);
    check_val("rst_s_gnt", s_gnt, 0);
    check_val("rst_rsp_valid", s_rsp_valid, 0);
    check_val("rst_m_req", m_req, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_orphan", orphan_err, 0);

    // single requester read with a 2-cycle response
    do_reset();
    chk_data = 1'b0;
    s_req = 3'b001; s_addr[0] = 32'h000A_8F78; s_be[0] = 4'hF; m_gnt = 1'b1;
    step();
    check_val("single_gnt", gnt_obs, 3'b001);
    s_req = '0;
    step();
    step();
    m_rsp_valid = 1'b1; m_rsp_rdata = 32'h0240_9F96; m_rsp_error = 1'b0;
    step();
    check_val("single_rsp", rsp_obs, 3'b001);
    check_val("single_rdata", rdata_obs, 32'h0240_9F96);
    check_val("single_busy_rsp", busy_obs, 1'b1);
    m_rsp_valid = 1'b0;
    step();
    check_val("single_busy_after", busy_obs, 1'b0);

    // fairness with all three requesting continuously
    do_reset();
    chk_data = 1'b1;
    m_gnt = 1'b1; s_req = 3'b111;
    for (int i = 0; i < NUM_REQ; i++) s_addr[i] = {8'(i), 24'h000100};
    for (int n = 0; n < 6; n++) begin
      drive_mem(1'b1);
      step();
      check_val("fair_order", onehot_idx(gnt_obs), order_exp[n]);
      for (int i = 0; i < NUM_REQ; i++) if (gnt_obs[i]) s_addr[i] = {8'(i), 24'(n + 2)};
    end
    drain();

    // stall: a held request keeps m_addr stable even when a later requester would win
    do_reset();
    m_gnt = 1'b1; s_req = 3'b010; s_addr[1] = 32'h1111_0000;
    step();
    s_req = '0; drive_mem(1'b1);
    step();
    m_rsp_valid = 1'b0; m_gnt = 1'b0;
    s_req = 3'b010; s_addr[1] = 32'h1111_0040;
    step();
    check_val("lock_addr", maddr_obs, 32'h1111_0040);
    s_req = 3'b110; s_addr[2] = 32'h2222_0080;
    for (int n = 0; n < 4; n++) begin
      step();
      check_val("lock_addr", maddr_obs, 32'h1111_0040);
    end
    m_gnt = 1'b1;
    step();
    check_val("lock_first_gnt", gnt_obs, 3'b010);
    s_req = 3'b100;
    step();
    check_val("lock_second_gnt", gnt_obs, 3'b100);
    drain();

    // FIFO full: back-to-back requests with no responses
    do_reset();
    m_gnt = 1'b1; s_req = 3'b001; s_addr[0] = 32'h0000_1000;
    grants = 0;
    for (int n = 0; n < 6; n++) begin
      step();
      if (gnt_obs[0]) begin
        grants++;
        s_addr[0] = s_addr[0] + 32'h10;
      end
    end
    check_val("full_grants", grants, 4);
    check_val("full_m_req", mreq_obs, 1'b0);
    drive_mem(1'b1);
    step();
    check_val("full_pop_cycle_gnt", gnt_obs, 3'b000);
    m_rsp_valid = 1'b0;
    step();
    if (gnt_obs[0]) grants++;
    check_val("full_resume_grants", grants, 5);
    check_val("full_resume_m_req", mreq_obs, 1'b1);
    drain();

    // grant and response in the same cycle with three outstanding
    do_reset();
    m_gnt = 1'b1; s_req = 3'b001;
    for (int n = 0; n < 3; n++) begin
      s_addr[0] = 32'h0000_2000 + 32'(n * 16);
      step();
    end
    s_req = 3'b010; s_addr[1] = 32'h0100_3000;
    drive_mem(1'b1);
    step();
    check_val("simul_rsp", rsp_obs, 3'b001);
    check_val("simul_gnt", gnt_obs, 3'b010);
    m_rsp_valid = 1'b0; s_req = 3'b001; s_addr[0] = 32'h0000_2040;
    step();
    check_val("simul_count3_gnt", gnt_obs, 3'b001);
    s_addr[0] = 32'h0000_2050;
    step();
    check_val("simul_full", mreq_obs, 1'b0);
    drain();

    // orphans: responses after a reset that discarded two outstanding transactions
    do_reset();
    m_gnt = 1'b1; s_req = 3'b001;
    step();
    s_addr[0] = 32'h0000_4010;
    step();
    do_reset();
    m_rsp_valid = 1'b1; m_rsp_rdata = 32'hDEAD_0001;
    step();
    check_val("orphan_rsp0", rsp_obs, 3'b000);
    step();
    check_val("orphan_rsp1", rsp_obs, 3'b000);
    m_rsp_valid = 1'b0;
    repeat (3) step();
    check_val("orphan_sticky", orphan_obs, 1'b1);
    do_reset();
    step();
    check_val("orphan_cleared", orphan_obs, 1'b0);

    // random traffic
    do_reset();
    chk_data = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!s_req[i] && $urandom_range(0, 2) == 0) begin
          s_req[i]   = 1'b1;
          s_addr[i]  = $urandom;
          s_we[i]    = 1'($urandom);
          s_wdata[i] = $urandom;
          s_be[i]    = 4'($urandom);
        end
      end
      m_gnt = ($urandom_range(0, 3) != 0);
      drive_mem($urandom_range(0, 2) != 0);
      step();
      for (int i = 0; i < NUM_REQ; i++) if (gnt_obs[i]) s_req[i] = 1'b0;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
